// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a single 1-bit full adder steps through the operands LSB first,
// one bit per clock, and publishes {carry_out, sum_out} when the last bit is done.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic carry_in,
  output logic SUM,
  output logic carry_out
);
  assign SUM       = A ^ B ^ carry_in;
  assign carry_out = (A & B) | (carry_in & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sumShift_q, sumShift_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sumOut_q, sumOut_d;
  logic             carryOut_q, carryOut_d;

  logic faSum;
  logic faCarry;

  full_adder u_fa (
    .A         (aShift_q[0]),
    .B         (bShift_q[0]),
    .carry_in  (carry_q),
    .SUM       (faSum),
    .carry_out (faCarry)
  );

  // The full adder is wired permanently; its outputs are only captured while in RUN.
  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    sumShift_d = sumShift_q;
    carry_d    = carry_q;
    count_d    = count_q;
    sumOut_d   = sumOut_q;
    carryOut_d = carryOut_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aShift_d = a_in;
          bShift_d = b_in;
          carry_d  = carry_in;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sumShift_d = {faSum, sumShift_q[WIDTH-1:1]};
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        carry_d    = faCarry;
        count_d    = count_q + 1'b1;
        // The final bit goes straight into the published result, not via sumShift_q.
        if (count_q == LAST_BIT) begin
          sumOut_d   = {faSum, sumShift_q[WIDTH-1:1]};
          carryOut_d = faCarry;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      sumOut_q   <= '0;
      carryOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      sumShift_q <= sumShift_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      sumOut_q   <= sumOut_d;
      carryOut_q <= carryOut_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum_out   = sumOut_q;
  assign carry_out = carryOut_q;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on clk rising edge.
REQ-005 Port: a_in  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-006 Port: b_in  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-007 Port: carry_in  input  1  initial carry; sampled only on the accepting edge.
REQ-008 Port: busy  output  1  high while serial addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking result valid.
REQ-010 Port: sum_out  output  WIDTH  registered result sum.
REQ-011 Port: carry_out  output  1  registered final carry.

Function
REQ-012 The block SHALL compute {carry_out, sum_out} = a_in + b_in + carry_in using exactly one instance of the team's 1-bit full_adder (ports A, B, carry_in, SUM, carry_out), LSB first, one bit per cycle.
REQ-013 Internal state SHALL be: A and B shift registers, sum shift register, 1-bit carry flip-flop, bit counter of ceil(log2(WIDTH)) bits, FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: busy=0, done=0; on an edge with start=1, load A/B shift registers from a_in/b_in, carry flip-flop from carry_in, counter to 0, go to RUN.
REQ-015 RUN: busy=1, done=0; each edge SHALL shift full_adder SUM into sum register MSB (shift right), shift A/B right by one, load carry flip-flop from full_adder carry_out, increment counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge on which counter equals WIDTH-1 SHALL move to DONE and update sum_out and carry_out with the complete result.
REQ-017 DONE: busy=0, done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge k, busy SHALL be high for cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1.
REQ-019 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-020 Changes to a_in, b_in, carry_in after the accepting edge SHALL NOT affect the result in progress.
REQ-021 sum_out and carry_out SHALL hold their last value from DONE entry until the next DONE entry, including through IDLE and RUN.
REQ-022 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after DONE, giving one operation every WIDTH+2 cycles.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH in sum_out, with overflow reflected only in carry_out.
REQ-024 The full_adder SHALL always see A/B shift register bit 0 and the carry flip-flop; its outputs SHALL only be consumed in RUN.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force FSM=IDLE, busy=0, done=0, sum_out=0, carry_out=0, counter=0, carry flip-flop=0, all shift registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-027 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, a_in=8'hFF, b_in=8'h01, carry_in=0, start pulse -> busy high 8 cycles, done in cycle 9, sum_out=8'h00, carry_out=1.
REQ-029 WIDTH=8, a_in=8'hA5, b_in=8'h5A, carry_in=1 -> sum_out=8'h00, carry_out=1; a_in=0, b_in=0, carry_in=1 -> sum_out=8'h01, carry_out=0.
REQ-030 Start pulsed again and a_in/b_in changed during RUN -> no restart, result matches the original operands, exactly one done pulse.
REQ-031 rst_n low for 1 cycle at RUN cycle 4 -> busy/done/sum_out/carry_out drop to 0 asynchronously; no done afterward; next start yields correct sum.
REQ-032 start held high continuously for 3 operations -> done pulses spaced exactly WIDTH+2 cycles apart, each result correct.
REQ-033 Random sweep, WIDTH=8 and WIDTH=3, 1000 operand pairs -> {carry_out, sum_out} equals a_in+b_in+carry_in for every operation.
